// File: rtl/shift_seq_arbiter.sv
// Round-robin arbiter that owns a WIDTH-stage external serial shift chain:
// flushes it, shifts the granted word in LSB-first, then checks the parallel taps.
module shift_seq_arbiter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sr_clear,
    output logic             sr_in,
    input  logic [WIDTH-1:0] q_par,
    output logic             busy,
    output logic             done,
    output logic             owner,
    output logic [WIDTH-1:0] result,
    output logic             match,
    output logic             err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_SHIFT,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] word_reg, word_next;
    logic             owner_reg, owner_next;
    logic             rr_reg, rr_next;

    logic             gnt0_reg, gnt1_reg, sr_clear_reg, busy_reg, done_reg;
    logic [WIDTH-1:0] result_reg;
    logic             match_reg, err_reg;

    logic             grant_any;
    logic             grant_sel;

    // With both requesting the rr pointer decides; otherwise the lone requester wins.
    assign grant_any = req0 | req1;
    assign grant_sel = (req0 && req1) ? rr_reg : req1;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        word_next  = word_reg;
        owner_next = owner_reg;
        rr_next    = rr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_any) begin
                    state_next = ST_CLR;
                    word_next  = grant_sel ? data1 : data0;
                    owner_next = grant_sel;
                    rr_next    = ~grant_sel;
                end
            end
            ST_CLR: begin
                state_next = ST_SHIFT;
                cnt_next   = '0;
            end
            ST_SHIFT: begin
                if (cnt_reg == LAST_CNT) begin
                    state_next = ST_CHECK;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_CHECK: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            word_reg     <= '0;
            owner_reg    <= 1'b0;
            rr_reg       <= 1'b0;
            gnt0_reg     <= 1'b0;
            gnt1_reg     <= 1'b0;
            sr_clear_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            result_reg   <= '0;
            match_reg    <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            word_reg     <= word_next;
            owner_reg    <= owner_next;
            rr_reg       <= rr_next;
            // Status outputs are registered from the next state so they line up with it.
            gnt0_reg     <= (state_reg == ST_IDLE) && grant_any && !grant_sel;
            gnt1_reg     <= (state_reg == ST_IDLE) && grant_any && grant_sel;
            sr_clear_reg <= (state_next == ST_CLR);
            busy_reg     <= (state_next != ST_IDLE);
            done_reg     <= (state_next == ST_DONE);
            if (state_reg == ST_CHECK) begin
                result_reg <= q_par;
                match_reg  <= (q_par == word_reg);
                if (q_par != word_reg) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    assign sr_in    = (state_reg == ST_SHIFT) && word_reg[cnt_reg];
    assign gnt0     = gnt0_reg;
    assign gnt1     = gnt1_reg;
    assign sr_clear = sr_clear_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign owner    = owner_reg;
    assign result   = result_reg;
    assign match    = match_reg;
    assign err      = err_reg;

endmodule

// File: doc/shift_seq_arbiter.md
Name: shift_seq_arbiter

Overview:
- Controller that shares the 4-stage serial shift-register datapath between two requesters.
- Arbitrates parallel-word requests round-robin and flushes the register chain.
- Serialises the granted word LSB-first onto the chain's serial input, then reads back the chain's parallel taps.
- Reports the captured word, the owner, and a compare-match flag.

Parameters:
- WIDTH, 4, number of register stages and word width; must equal the chain length.
- CNT_W, 2, bit-counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 transfer request; level, held until gnt0.
- data0  in  WIDTH  requester 0 word; sampled on the grant edge.
- req1  in  1  requester 1 transfer request.
- data1  in  WIDTH  requester 1 word.
- gnt0  out  1  one-cycle grant pulse to requester 0.
- gnt1  out  1  one-cycle grant pulse to requester 1.
- sr_clear  out  1  registered flush pulse to the chain's clear input.
- sr_in  out  1  serial bit to the chain input; 0 outside SHIFT.
- q_par  in  WIDTH  chain parallel taps; q_par[0] is the oldest stage.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- owner  out  1  requester index of the completed transfer; valid with done.
- result  out  WIDTH  q_par as captured in CHECK; held until the next done.
- match  out  1  result equals the granted word; valid with done.
- err  out  1  sticky mismatch flag; cleared only by clear.

Behaviour:
- Reset (clear=1, async): state=IDLE, rr pointer=0 (req0 preferred). gnt0, gnt1, sr_clear, sr_in, busy, done, owner, match and err all 0; result=0.
- States: IDLE -> CLR -> SHIFT -> CHECK -> DONE -> IDLE.
- IDLE:
  - At a clock edge with any req high, select the requester.
  - Only one requesting: that one.
  - Both requesting: the one the rr pointer names.
  - Latch its data into the shift buffer, latch owner, toggle the rr pointer to the other index, and go to CLR.
- CLR (1 cycle):
  - The granted gnt pulses high for exactly this cycle; sr_clear=1 and busy=1.
  - Next state SHIFT with bit counter=0.
- SHIFT (exactly WIDTH cycles):
  - sr_in = shift buffer bit[counter], LSB first.
  - The chain shifts on every edge, so after WIDTH edges q_par[i] = word[i].
  - When counter = WIDTH-1, go to CHECK.
- CHECK (1 cycle):
  - sr_in=0.
  - At the closing edge: result <= q_par, match <= (q_par == latched word); if they differ, err <= 1.
- DONE (1 cycle): done=1; owner, result and match are valid. Next state IDLE.
- Latency: request sampled at edge E -> gnt and sr_clear in cycle E+1 -> done in cycle E+WIDTH+3.
  - For WIDTH=4: done in cycle E+7.
  - Back-to-back throughput: one transfer per WIDTH+4 cycles.
- Requests arriving while busy=1 are not granted; they are re-evaluated on the first IDLE edge.
- A req dropped before its grant edge causes no transfer.
- data changes after the grant edge are ignored.
- err stays high through later matching transfers and remains high until clear.
- Mid-operation clear: immediate abort to reset values. No done is issued for the aborted transfer; the rr pointer returns to 0.
- All outputs are registered, except sr_in, which is decoded from state plus the buffer bit and is glitch-free relative to clock.

Test Plan:
- Reset, then req0=1, data0=4'b1011 -> gnt0 high in cycle 1; sr_clear in cycle 1; sr_in sequence 1,1,0,1 in cycles 2-5; done in cycle 7 with owner=0, result=4'b1011, match=1, err=0.
- req0 and req1 both high from reset, data0=4'h5, data1=4'hA -> req0 granted first (done, owner=0, result=5). Next IDLE edge grants req1 (owner=1, result=A). Third transfer goes to req0.
- req1 asserted mid-transfer of req0 -> no gnt1 until busy falls. gnt1 appears 1 cycle after the first IDLE edge; no lost or duplicate grants.
- Bench forces q_par=4'h0 during CHECK for data0=4'hF -> done with match=0, result=0, err=1. A following correct transfer gives match=1 while err stays 1.
- clear pulsed during SHIFT (cycle 3) -> all outputs 0 immediately, no done. A subsequent req1 alone is granted (pointer=0 does not block it) and completes normally.
- req0 pulsed one cycle while busy, then dropped -> never granted; gnt0 stays 0.
